// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if: channel inputs and registered output handshake of the N:1 mux
interface mux_rr_n_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    logic                 mode;
    logic [CW-1:0]        sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_valid;
    logic                 out_ready;
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel fixed-select / round-robin mux with a registered output stage
module mux_rr_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    mux_rr_n_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    chan_q, chan_d, ptr_q, ptr_d, gnt, idx;
    logic             valid_q, valid_d, gnt_vld, load_en, accept;
    // pick the granted channel: scan from ptr+1 with wrap in round-robin, or match sel in fixed mode
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = bus.mode ? CW'((int'(ptr_q) + k) % N) : CW'(k - 1);
            if (!gnt_vld && bus.in_valid[idx] && (bus.mode || bus.sel == idx)) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end
    assign load_en      = !valid_q || bus.out_ready;
    assign accept       = load_en && gnt_vld && !rst;
    assign bus.in_ready = accept ? (N'(1) << gnt) : '0;
    // next output register contents: load on accept, drop valid once drained
    always_comb begin
        data_d  = accept ? bus.in_data[int'(gnt)*WIDTH +: WIDTH] : data_q;
        chan_d  = accept ? gnt : chan_q;
        ptr_d   = accept ? gnt : ptr_q;
        valid_d = accept || (valid_q && !bus.out_ready);
    end
    // output register and round-robin pointer; reset points at N-1 so channel 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= CW'(N - 1);
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed and random checks of mux_rr_n (N=4 and N=3) against a reference model
module tb_mux_rr_n;
    logic        clk = 1'b0;
    logic        rst, mode, ordy;
    logic [1:0]  sel;
    logic [3:0]  vin;
    logic [31:0] din;
    int          checks = 0;
    int          errors = 0;
    bit          mv[2];
    logic [7:0]  md[2];
    int          mc[2];
    int          mp[2];
    int          nn[2] = '{4, 3};
    int          rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    always #5 clk = ~clk;

    mux_rr_n_if #(.N(4), .WIDTH(8)) b4 ();
    mux_rr_n_if #(.N(3), .WIDTH(8)) b3 ();

    assign b4.mode      = mode;
    assign b4.sel       = sel;
    assign b4.in_valid  = vin;
    assign b4.in_data   = din;
    assign b4.out_ready = ordy;
    assign b3.mode      = mode;
    assign b3.sel       = sel;
    assign b3.in_valid  = vin[2:0];
    assign b3.in_data   = din[23:0];
    assign b3.out_ready = ordy;

    mux_rr_n #(.N(4), .WIDTH(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_rr_n #(.N(3), .WIDTH(8)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grant(int n, bit md_, int s, logic [3:0] v, int p);
        if (!md_) return (s < n && v[s]) ? s : -1;
        for (int d = 1; d <= n; d++)
            if (v[(p + d) % n]) return (p + d) % n;
        return -1;
    endfunction

    task automatic cycle();
        int         g[2];
        bit         acc[2];
        logic [3:0] vv;
        #1;
        for (int u = 0; u < 2; u++) begin
            vv     = u ? {1'b0, vin[2:0]} : vin;
            g[u]   = ref_grant(nn[u], mode, int'(sel), vv, mp[u]);
            acc[u] = !rst && g[u] >= 0 && (!mv[u] || ordy);
            chk(u ? "in_ready3" : "in_ready4", u ? 32'(b3.in_ready) : 32'(b4.in_ready),
                acc[u] ? (32'd1 << g[u]) : 32'd0);
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                mv[u] = 1'b0; md[u] = '0; mc[u] = 0; mp[u] = nn[u] - 1;
            end else if (acc[u]) begin
                mv[u] = 1'b1; md[u] = din[g[u]*8 +: 8]; mc[u] = g[u]; mp[u] = g[u];
            end else if (ordy) begin
                mv[u] = 1'b0;
            end
        end
        chk("out_valid4", 32'(b4.out_valid), 32'(mv[0]));
        chk("out_data4",  32'(b4.out_data),  32'(md[0]));
        chk("out_chan4",  32'(b4.out_chan),  32'(mc[0]));
        chk("out_valid3", 32'(b3.out_valid), 32'(mv[1]));
        chk("out_data3",  32'(b3.out_data),  32'(md[1]));
        chk("out_chan3",  32'(b3.out_chan),  32'(mc[1]));
    endtask

    initial begin
        mp[0] = 3; mp[1] = 2;
        rst = 1'b1; mode = 1'b1; sel = 2'd0; vin = 4'hF; ordy = 1'b1; din = 32'hA3A2A1A0;
        cycle();
        cycle();
        chk("reset_valid", 32'(b4.out_valid), 32'd0);
        chk("reset_data",  32'(b4.out_data),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_seq", 32'(b4.out_chan), 32'(rr_exp[i]));
        end
        vin = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_alt", 32'(b4.out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        mode = 1'b0; sel = 2'd2; vin = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fixed_rdy", 32'(b4.in_ready), 32'b0100);
            cycle();
            chk("fixed_data", 32'(b4.out_data), 32'hA2);
            chk("fixed_chan", 32'(b4.out_chan), 32'd2);
        end
        sel = 2'd1;
        cycle();
        chk("bp_load", 32'(b4.out_chan), 32'd1);
        mode = 1'b1; ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_chan", 32'(b4.out_chan), 32'd1);
            chk("bp_hold_data", 32'(b4.out_data), 32'hA1);
        end
        ordy = 1'b1;
        cycle();
        chk("bp_release", 32'(b4.out_chan), 32'd2);
        chk("bp_nobubble", 32'(b4.out_valid), 32'd1);
        mode = 1'b0; sel = 2'd3;
        cycle();
        chk("oor_drain3", 32'(b3.out_valid), 32'd0);
        chk("oor_chan4", 32'(b4.out_chan), 32'd3);
        cycle();
        mode = 1'b1; vin = 4'h0;
        cycle();
        cycle();
        chk("idle_valid", 32'(b4.out_valid), 32'd0);
        vin = 4'hF;
        cycle();
        ordy = 1'b0; rst = 1'b1;
        cycle();
        chk("midrst_valid", 32'(b4.out_valid), 32'd0);
        rst = 1'b0; ordy = 1'b1;
        cycle();
        chk("midrst_chan", 32'(b4.out_chan), 32'd0);
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(31) == 0);
            mode = 1'($urandom_range(1));
            sel  = 2'($urandom_range(3));
            vin  = 4'($urandom_range(15));
            din  = $urandom;
            ordy = ($urandom_range(3) != 0);
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
Parametrised N-channel successor to the 2:1 behavioural mux. Selects one of N valid/ready input channels and forwards its data through a single registered output stage. Supports two modes: fixed select (the classic mux, sel input) and round-robin arbitration. Sits between multiple producers and one shared consumer, for example a shared bus or output port.

Parameters:
N, 4, number of input channels (N >= 2)
WIDTH, 8, data width per channel
CW, $clog2(N), channel index width (derived; localparam, minimum 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
mode  input  1  0 = fixed select by sel, 1 = round-robin
sel  input  CW  channel index used when mode = 0
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
out_data  output  WIDTH  registered selected data
out_chan  output  CW  registered index of the channel held in out_data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (sampled at a clk edge with rst=1):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority.
  - rst overrides any transfer in the same cycle, including one in flight. No in_ready is asserted while rst=1.
- load_en = !out_valid || out_ready. The output register may load every cycle, giving full throughput with no bubble.
- Grant, combinational, evaluated every cycle:
  - mode=0: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants.
  - mode=1: grant = first i with in_valid[i]=1, scanning (ptr+1) mod N, (ptr+2) mod N, ..., ptr, with wrap-around.
- in_ready[g] = load_en && grant valid && !rst. All other in_ready bits are 0, and at most one bit is set.
- Accept (in_valid[g] && in_ready[g]) at an edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1, ptr <= g (in both modes).
- Output side:
  - If out_ready=1 with out_valid=1 and there is no accept, then out_valid <= 0.
  - If out_valid=1 and out_ready=0, then out_data, out_chan and out_valid hold stable. All in_ready are 0.
- Latency: 1 cycle from input accept to out_valid.
- Simultaneous output drain and new accept in the same cycle: the new word replaces the old one and out_valid stays 1.
- Mode or sel change: takes effect at the next grant decision and never alters a word already held in the output register.
- Fairness (mode=1): with all channels continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,... and no channel starves.
- A channel dropping in_valid before it is granted is legal. No state is retained for it.
- in_data of non-granted channels is ignored. The block has no X-propagation dependence on unselected channels.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000. The first grant after release (mode=1) is channel 0.
- Fixed mode: mode=0, sel=2, in_valid=1111, in_data ch i = 8'hA0+i, out_ready=1 -> out_data=8'hA2, out_chan=2 every cycle; in_ready=0100.
- Round-robin: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid=1010 -> grants alternate 1,3.
- Backpressure: hold out_ready=0 for 3 cycles after the word from ch1 loads -> out_data/out_chan stay at ch1, in_ready=0000. On out_ready=1, ch2 is loaded on the same edge with no bubble.
- Out-of-range and idle: mode=0, sel=3 with N=3 (CW=2), in_valid=111 -> no grant, and out_valid falls to 0 after draining. Separately, in_valid=0000 -> out_valid=0.
- Reset mid-operation: out_valid=1, out_ready=0, assert rst for 1 cycle -> out_valid=0, ptr is reset, and the next round-robin grant is channel 0.
